// File: rtl/load_use_stall_ctrl.sv
// Decode-stage hazard control: holds PC and IF/ID for a load-use hazard while EX takes bubbles,
// flushes IF/ID and ID/EX on a taken branch, and keeps a saturating count of stall cycles.
module load_use_stall_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_valid,
  input  logic [6:0]       ex_opcode,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  localparam int REM_W    = (LOAD_LAT > 2) ? $clog2(LOAD_LAT) : 1;
  localparam int REM_INIT = (LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1
  } state_t;

  state_t           state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic use_rs1, use_rs2, hz, cnt_inc;

  // Only register fields the opcode really reads; immediate bits never match.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (id_opcode)
      OP_LW, OP_ADDI:     use_rs1 = 1'b1;
      OP_SW, OP_R, OP_BR: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  assign hz = id_valid && ex_valid && (ex_opcode == OP_LW) && (ex_rd != 5'd0) &&
              ((use_rs1 && (id_rs1 == ex_rd)) || (use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    cnt_inc      = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    stall_active = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (hz) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          cnt_inc      = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = STALL;
            rem_d   = REM_W'(REM_INIT);
          end
        end
      end
      STALL: begin
        stall_active = 1'b1;
        id_ex_bubble = 1'b1;
        if (ex_branch_taken) begin
          // A taken branch kills the waiting instruction, so the stall is abandoned uncounted.
          if_id_flush = 1'b1;
          state_d     = RUN;
          rem_d       = '0;
        end else begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          cnt_inc     = 1'b1;
          if (rem_q == '0) state_d = RUN;
          else             rem_d   = rem_q - REM_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_inc && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      rem_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_load_use_stall_ctrl.sv
// Directed bench for load_use_stall_ctrl: single-cycle vector table plus multi-cycle stall sequences.
module tb_load_use_stall_ctrl;

  localparam logic [6:0] LW = 7'b0000011, AD = 7'b0010011, SW = 7'b0100011;
  localparam logic [6:0] RR = 7'b0110011, BR = 7'b1100011, LUI = 7'b0110111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, id_valid, ex_valid, ex_branch_taken;
  logic [6:0] id_opcode, ex_opcode;
  logic [4:0] id_rs1, id_rs2, ex_rd;

  logic        pw1, iw1, fl1, bu1, sa1;
  logic [15:0] cnt1;
  logic        pw3, iw3, fl3, bu3, sa3;
  logic [15:0] cnt3;
  logic        pw4, iw4, fl4, bu4, sa4;
  logic [3:0]  cnt4;

  load_use_stall_ctrl #(.LOAD_LAT(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .pc_write(pw1), .if_id_write(iw1), .if_id_flush(fl1),
    .id_ex_bubble(bu1), .stall_active(sa1), .stall_cnt(cnt1));

  load_use_stall_ctrl #(.LOAD_LAT(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .pc_write(pw3), .if_id_write(iw3), .if_id_flush(fl3),
    .id_ex_bubble(bu3), .stall_active(sa3), .stall_cnt(cnt3));

  load_use_stall_ctrl #(.LOAD_LAT(1), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .pc_write(pw4), .if_id_write(iw4), .if_id_flush(fl4),
    .id_ex_bubble(bu4), .stall_active(sa4), .stall_cnt(cnt4));

  // exp_o = {pc_write, if_id_write, if_id_flush, id_ex_bubble, stall_active}
  typedef struct {
    string       name;
    logic        idv;
    logic [6:0]  op;
    logic [4:0]  rs1, rs2;
    logic        exv;
    logic [6:0]  exop;
    logic [4:0]  exrd;
    logic        br;
    logic [4:0]  exp_o;
    logic [15:0] exp_cnt;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic idv, input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic exv, input logic [6:0] exop, input logic [4:0] exrd, input logic br);
    id_valid = idv; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2;
    ex_valid = exv; ex_opcode = exop; ex_rd = exrd; ex_branch_taken = br;
    #1;
  endtask

  task automatic idle();
    drive(0, 7'd0, 5'd0, 5'd0, 0, 7'd0, 5'd0, 0);
  endtask

  task automatic hazard();
    drive(1, AD, 5'd5, 5'd0, 1, LW, 5'd5, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
  endtask

  vec_t vecs[16];

  initial begin
    reset = 1'b1;
    idle();
    vecs[0]  = '{"reset_idle",   0, 7'd0, 5'd0, 5'd0, 0, 7'd0, 5'd0,  0, 5'b11000, 16'd0};
    vecs[1]  = '{"lw5_addi5",    1, AD,   5'd5, 5'd0, 1, LW,   5'd5,  0, 5'b00010, 16'd0};
    vecs[2]  = '{"after_stall",  0, 7'd0, 5'd0, 5'd0, 0, 7'd0, 5'd0,  0, 5'b11000, 16'd1};
    vecs[3]  = '{"rd0_no_stall", 1, AD,   5'd0, 5'd0, 1, LW,   5'd0,  0, 5'b11000, 16'd1};
    vecs[4]  = '{"sw_rs2",       1, SW,   5'd2, 5'd7, 1, LW,   5'd7,  0, 5'b00010, 16'd1};
    vecs[5]  = '{"addi_imm",     1, AD,   5'd2, 5'd7, 1, LW,   5'd7,  0, 5'b11000, 16'd2};
    vecs[6]  = '{"r_rs2",        1, RR,   5'd3, 5'd9, 1, LW,   5'd9,  0, 5'b00010, 16'd2};
    vecs[7]  = '{"br_rs1",       1, BR,   5'd9, 5'd1, 1, LW,   5'd9,  0, 5'b00010, 16'd3};
    vecs[8]  = '{"lw_rs2_imm",   1, LW,   5'd4, 5'd9, 1, LW,   5'd9,  0, 5'b11000, 16'd4};
    vecs[9]  = '{"lw_rs1",       1, LW,   5'd9, 5'd0, 1, LW,   5'd9,  0, 5'b00010, 16'd4};
    vecs[10] = '{"ex_not_load",  1, AD,   5'd9, 5'd0, 1, AD,   5'd9,  0, 5'b11000, 16'd5};
    vecs[11] = '{"ex_bubble",    1, AD,   5'd9, 5'd0, 0, LW,   5'd9,  0, 5'b11000, 16'd5};
    vecs[12] = '{"id_invalid",   0, AD,   5'd9, 5'd0, 1, LW,   5'd9,  0, 5'b11000, 16'd5};
    vecs[13] = '{"lui_no_use",   1, LUI,  5'd9, 5'd9, 1, LW,   5'd9,  0, 5'b11000, 16'd5};
    vecs[14] = '{"branch_wins",  1, AD,   5'd9, 5'd0, 1, LW,   5'd9,  1, 5'b11110, 16'd5};
    vecs[15] = '{"final_idle",   0, 7'd0, 5'd0, 5'd0, 0, 7'd0, 5'd0,  0, 5'b11000, 16'd5};

    tick();
    tick();
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].idv, vecs[i].op, vecs[i].rs1, vecs[i].rs2,
            vecs[i].exv, vecs[i].exop, vecs[i].exrd, vecs[i].br);
      chk({vecs[i].name, "_out"}, {pw1, iw1, fl1, bu1, sa1}, vecs[i].exp_o);
      chk({vecs[i].name, "_cnt"}, cnt1, vecs[i].exp_cnt);
      tick();
    end

    // Three-cycle stall, hazard inputs held throughout.
    do_reset();
    hazard();
    chk("lat3_c1", {pw3, iw3, fl3, bu3, sa3}, 5'b00010);
    tick();
    hazard();
    chk("lat3_c2", {pw3, iw3, fl3, bu3, sa3}, 5'b00011);
    tick();
    hazard();
    chk("lat3_c3", {pw3, iw3, fl3, bu3, sa3}, 5'b00011);
    tick();
    idle();
    chk("lat3_release", {pw3, iw3, fl3, bu3, sa3}, 5'b11000);
    chk("lat3_cnt", cnt3, 32'd3);
    tick();

    // Taken branch in the second stall cycle aborts without counting.
    do_reset();
    hazard();
    chk("abort_c1", {pw3, iw3, fl3, bu3, sa3}, 5'b00010);
    tick();
    drive(1, AD, 5'd5, 5'd0, 1, LW, 5'd5, 1);
    chk("abort_c2", {pw3, iw3, fl3, bu3, sa3}, 5'b11111);
    tick();
    idle();
    chk("abort_run", {pw3, iw3, fl3, bu3, sa3}, 5'b11000);
    chk("abort_cnt", cnt3, 32'd1);
    tick();

    // Reset taken while in STALL.
    do_reset();
    hazard();
    tick();
    hazard();
    chk("rst_mid_in_stall", sa3, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    chk("rst_mid_out", {pw3, iw3, fl3, bu3, sa3}, 5'b11000);
    chk("rst_mid_cnt", cnt3, 32'd0);
    tick();

    // Saturation of a 4-bit counter.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      hazard();
      if (k == 14) chk("sat_cnt_14", cnt4, 32'd14);
      tick();
    end
    idle();
    chk("sat_cnt_final", cnt4, 32'd15);
    chk("sat_out_idle", {pw4, iw4, fl4, bu4, sa4}, 5'b11000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
